// File: rtl/lzx_trafficlights_monitor.sv
// Multi-channel traffic-light monitor: debounced one-hot check plus G->Y->R->G
// sequence check per channel, with software-clearable sticky fault flags.
module lzx_trafficlights_monitor #(
  parameter int N_CH  = 2,
  parameter int DEB   = 3,
  parameter int CNT_W = $clog2(DEB + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   R,
  input  logic [N_CH-1:0]   Y,
  input  logic [N_CH-1:0]   G,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   ohe,
  output logic [N_CH-1:0]   seqe,
  output logic [N_CH-1:0]   Z,
  output logic [2*N_CH-1:0] st,
  output logic              any_fault
);

  // state     | meaning
  // S_INIT    | no valid lamp seen since reset; next valid lamp accepted unchecked
  // S_GREEN   | last valid lamp was green
  // S_YELLOW  | last valid lamp was yellow
  // S_RED     | last valid lamp was red
  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_RED    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           st_q, st_d, lamp_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ohe_q, ohe_d;
    logic             seqe_q, seqe_d;
    logic             valid, legal, seq_err, ohe_set;

    always_comb begin
      valid   = ({R[i], Y[i], G[i]} == 3'b100) || ({R[i], Y[i], G[i]} == 3'b010) ||
                ({R[i], Y[i], G[i]} == 3'b001);
      lamp_st = G[i] ? S_GREEN : (Y[i] ? S_YELLOW : S_RED);
      legal   = (st_q == S_GREEN  && lamp_st == S_YELLOW) ||
                (st_q == S_YELLOW && lamp_st == S_RED)    ||
                (st_q == S_RED    && lamp_st == S_GREEN);
      seq_err = valid && (st_q != S_INIT) && (lamp_st != st_q) && !legal;

      st_d = valid ? lamp_st : st_q;

      if (valid)               cnt_d = '0;
      else if (cnt_q == DEB_C) cnt_d = cnt_q;
      else                     cnt_d = cnt_q + CNT_W'(1);

      // Re-asserts on every saturated illegal sample so a clear cannot mask a live fault.
      ohe_set = !valid && (cnt_d == DEB_C);
      ohe_d   = ohe_set | (ohe_q & ~clr[i]);
      seqe_d  = seq_err | (seqe_q & ~clr[i]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= S_INIT;
        cnt_q  <= '0;
        ohe_q  <= 1'b0;
        seqe_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        ohe_q  <= ohe_d;
        seqe_q <= seqe_d;
      end
    end

    assign ohe[i]         = ohe_q;
    assign seqe[i]        = seqe_q;
    assign st[2*i +: 2]   = st_q;
  end

  assign Z         = ohe | seqe;
  assign any_fault = |Z;

endmodule

// File: tb/tb_lzx_trafficlights_monitor.sv
// Table-driven bench for lzx_trafficlights_monitor (N_CH=2, DEB=3) with an
// expected-result queue popped one cycle after each stimulus edge.
module tb_lzx_trafficlights_monitor;

  localparam logic [2:0] LOFF = 3'b000, LG = 3'b001, LY = 3'b010, LR = 3'b100;
  localparam logic [2:0] LRY = 3'b110, LALL = 3'b111;

  typedef struct {
    logic       rst;
    logic [2:0] l0;    // {R,Y,G} for ch0
    logic [2:0] l1;    // {R,Y,G} for ch1
    logic [1:0] clr;
    logic [3:0] st;
    logic [1:0] ohe;
    logic [1:0] seqe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] R, Y, G, clr;
  logic [1:0] ohe, seqe, Z;
  logic [3:0] st;
  logic       any_fault;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  lzx_trafficlights_monitor #(.N_CH(2), .DEB(3)) dut (
    .clk(clk), .rst(rst), .R(R), .Y(Y), .G(G), .clr(clr),
    .ohe(ohe), .seqe(seqe), .Z(Z), .st(st), .any_fault(any_fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [2:0] a, logic [2:0] b, logic [1:0] c,
                              logic [3:0] s, logic [1:0] o, logic [1:0] q);
    vec_t v;
    v.rst = r; v.l0 = a; v.l1 = b; v.clr = c; v.st = s; v.ohe = o; v.seqe = q;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, req);
    end
  endtask

  task automatic step(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; clr = v.clr;
    R = {v.l1[2], v.l0[2]};
    Y = {v.l1[1], v.l0[1]};
    G = {v.l1[0], v.l0[0]};
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("st",        idx, st,                {e.st});
    check("ohe",       idx, {2'b00, ohe},      {2'b00, e.ohe});
    check("seqe",      idx, {2'b00, seqe},     {2'b00, e.seqe});
    check("Z",         idx, {2'b00, Z},        {2'b00, e.ohe | e.seqe});
    check("any_fault", idx, {3'b000, any_fault}, {3'b000, |(e.ohe | e.seqe)});
  endtask

  initial begin
    rst = 1'b1; clr = '0; R = '0; Y = '0; G = '0;

    // reset and legal cycle
    vecs.push_back(mk(1, LOFF, LOFF, 2'b00, 4'b0000, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LY,   LG,   2'b00, 4'b0110, 2'b00, 2'b00));
    vecs.push_back(mk(0, LY,   LG,   2'b00, 4'b0110, 2'b00, 2'b00));
    vecs.push_back(mk(0, LR,   LG,   2'b00, 4'b0111, 2'b00, 2'b00));
    vecs.push_back(mk(0, LR,   LG,   2'b00, 4'b0111, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    // short dark glitch, then debounce threshold with R+Y
    vecs.push_back(mk(0, LOFF, LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LOFF, LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LRY,  LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LRY,  LG,   2'b00, 4'b0101, 2'b00, 2'b00));
    vecs.push_back(mk(0, LRY,  LG,   2'b00, 4'b0101, 2'b01, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b01, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b01, 4'b0101, 2'b00, 2'b00));
    // illegal sequence on ch1, then legal R->G, then clear
    vecs.push_back(mk(0, LG,   LR,   2'b00, 4'b1101, 2'b00, 2'b10));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b10));
    vecs.push_back(mk(0, LG,   LG,   2'b10, 4'b0101, 2'b00, 2'b00));
    // glitch resync on ch0: Y, all-on, G
    vecs.push_back(mk(0, LY,   LG,   2'b00, 4'b0110, 2'b00, 2'b00));
    vecs.push_back(mk(0, LALL, LG,   2'b00, 4'b0110, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b01));
    // clear colliding with G->R fault, then quiet clear
    vecs.push_back(mk(0, LR,   LG,   2'b01, 4'b0111, 2'b00, 2'b01));
    vecs.push_back(mk(0, LR,   LG,   2'b01, 4'b0111, 2'b00, 2'b00));
    // clear while saturated illegal: ohe re-sets
    vecs.push_back(mk(0, LOFF, LG,   2'b00, 4'b0111, 2'b00, 2'b00));
    vecs.push_back(mk(0, LOFF, LG,   2'b00, 4'b0111, 2'b00, 2'b00));
    vecs.push_back(mk(0, LOFF, LG,   2'b00, 4'b0111, 2'b01, 2'b00));
    vecs.push_back(mk(0, LOFF, LG,   2'b01, 4'b0111, 2'b01, 2'b00));
    vecs.push_back(mk(0, LR,   LG,   2'b01, 4'b0111, 2'b00, 2'b00));
    // ch1-only fault, mid-run reset, unchecked first lamp
    vecs.push_back(mk(0, LR,   LY,   2'b00, 4'b1011, 2'b00, 2'b00));
    vecs.push_back(mk(0, LR,   LG,   2'b00, 4'b0111, 2'b00, 2'b10));
    vecs.push_back(mk(1, LR,   LR,   2'b01, 4'b0000, 2'b00, 2'b00));
    vecs.push_back(mk(0, LR,   LR,   2'b00, 4'b1111, 2'b00, 2'b00));
    vecs.push_back(mk(0, LG,   LG,   2'b00, 4'b0101, 2'b00, 2'b00));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // ch1 all lamps on for 5 cycles: ohe[1] from the 3rd edge, saturating
    for (int i = 0; i < 5; i++)
      step(mk(0, LG, LALL, 2'b00, 4'b0101, (i >= 2) ? 2'b10 : 2'b00, 2'b00), 100 + i);
    // clear with a legal G->Y on ch1 drops ohe
    step(mk(0, LG, LY, 2'b10, 4'b1001, 2'b00, 2'b00), 105);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
